// File: rtl/alu_trace_buffer_pkg.sv
// Shared definitions for the ALU trace buffer: FSM encodings, default widths
// and the capture-length helper.
package alu_trace_pkg;

    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_STAMP_W = 16;
    localparam int TRACE_ENTRY_W = TRACE_DATA_W + 1 + TRACE_STAMP_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // A zero-length capture still records the trigger sample.
    function automatic logic [7:0] cap_len_eff(input logic [7:0] len);
        logic [7:0] res;
        if (len == 8'd0) begin
            res = 8'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_trace_buffer_trace_fifo.sv
// Synchronous FIFO with a registered head: out_data/out_valid/count all come
// straight from flops and are preloaded with the entry that will be at the head.
module trace_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             pop_s;
    logic             full_s;
    logic             push_ok_s;
    logic [AW-1:0]    rd_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [CW-1:0]    remain_s;
    logic [WIDTH-1:0] head_nxt_s;

    assign pop_s     = valid_r & out_ready;
    assign full_s    = (count_r == CW'(DEPTH));
    assign push_ok_s = push & (~full_s | pop_s);
    assign remain_s  = count_r - CW'(pop_s);
    assign cnt_nxt_s = remain_s + CW'(push_ok_s);

    // Next read pointer advances only on an accepted pop.
    always_comb begin
        rd_nxt_s = rd_ptr_r;
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
    end

    // Head preload: when the FIFO drains to nothing but a push lands, that push
    // becomes the new head directly since it is not yet in mem_r.
    always_comb begin
        head_nxt_s = '0;
        if (cnt_nxt_s == CW'(0)) begin
            head_nxt_s = '0;
        end else if (remain_s == CW'(0)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_nxt_s;
            count_r  <= cnt_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (cnt_nxt_s != CW'(0));
        end
    end

    assign out_valid = valid_r;
    assign out_data  = head_r;
    assign count     = count_r;
    assign drop      = push & full_s & ~pop_s;

endmodule

// File: rtl/alu_trace_buffer.sv
// Debug capture stage: arms, waits for an ALU value/zero trigger, then records
// a run of timestamped ALU results into a FIFO drained over valid/ready.
module alu_trace_buffer
    import alu_trace_pkg::*;
#(
    parameter int DATA_W  = TRACE_DATA_W,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = TRACE_STAMP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       alu_output,
    input  logic                    zero,
    input  logic                    arm,
    input  logic [DATA_W-1:0]       trig_value,
    input  logic                    trig_on_zero,
    input  logic [7:0]              cap_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_zero,
    output logic [STAMP_W-1:0]      out_stamp,
    output logic [1:0]              state_o,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int ENTRY_W = DATA_W + 1 + STAMP_W;

    state_t             state_r;
    logic [STAMP_W-1:0] stamp_r;
    logic [7:0]         samp_cnt_r;
    logic [7:0]         cap_len_r;
    logic               overflow_r;

    logic               trig_s;
    logic               push_s;
    logic               drop_s;
    logic [STAMP_W-1:0] stamp_inc_s;
    logic [7:0]         len_eff_s;
    logic [ENTRY_W-1:0] fifo_head_s;

    assign trig_s    = (alu_output == trig_value) | (trig_on_zero & zero);
    assign len_eff_s = cap_len_eff(cap_len);

    // Saturating timestamp increment.
    always_comb begin
        stamp_inc_s = stamp_r;
        if (stamp_r == {STAMP_W{1'b1}}) begin
            stamp_inc_s = stamp_r;
        end else begin
            stamp_inc_s = stamp_r + STAMP_W'(1);
        end
    end

    // The trigger cycle itself is captured, then every CAPTURE cycle.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            ST_ARMED:   push_s = trig_s;
            ST_CAPTURE: push_s = 1'b1;
            default:    push_s = 1'b0;
        endcase
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({alu_output, zero, stamp_r}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_head_s),
        .count     (count),
        .drop      (drop_s)
    );

    // Capture FSM, timestamp, sample counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            stamp_r    <= '0;
            samp_cnt_r <= 8'd0;
            cap_len_r  <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // The arm cycle counts as stamp 0, so the first ARMED cycle reads 1.
                    if (arm) begin
                        state_r <= ST_ARMED;
                        stamp_r <= STAMP_W'(1);
                    end
                end
                ST_ARMED: begin
                    stamp_r <= stamp_inc_s;
                    if (trig_s) begin
                        cap_len_r  <= len_eff_s;
                        samp_cnt_r <= 8'd1;
                        state_r    <= (len_eff_s == 8'd1) ? ST_DONE : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    stamp_r <= stamp_inc_s;
                    if ((samp_cnt_r + 8'd1) == cap_len_r) begin
                        state_r <= ST_DONE;
                    end else begin
                        samp_cnt_r <= samp_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = fifo_head_s[ENTRY_W-1 -: DATA_W];
    assign out_zero  = fifo_head_s[STAMP_W];
    assign out_stamp = fifo_head_s[STAMP_W-1:0];
    assign state_o   = state_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_alu_trace_buffer.sv
// Directed bench for alu_trace_buffer: expected samples are queued as they are
// driven and compared against the FIFO head whenever a pop is accepted.
module tb_alu_trace_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] alu_output;
    logic        zero;
    logic        arm;
    logic [31:0] trig_value;
    logic        trig_on_zero;
    logic [7:0]  cap_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic [15:0] out_stamp;
    logic [1:0]  state_o;
    logic [4:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [48:0] sb [$];

    alu_trace_buffer #(.DATA_W(32), .DEPTH(16), .STAMP_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_output   (alu_output),
        .zero         (zero),
        .arm          (arm),
        .trig_value   (trig_value),
        .trig_on_zero (trig_on_zero),
        .cap_len      (cap_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_zero     (out_zero),
        .out_stamp    (out_stamp),
        .state_o      (state_o),
        .count        (count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted pop must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                assert (1'b0) else begin
                    n_fail++;
                    $error("FAIL sb_underflow observed=%0h expected=none", {out_data, out_zero, out_stamp});
                end
            end else begin
                logic [48:0] e;
                e = sb.pop_front();
                assert ({out_data, out_zero, out_stamp} === e) else begin
                    n_fail++;
                    $error("FAIL sb_pop observed=%0h expected=%0h", {out_data, out_zero, out_stamp}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_s(input logic [31:0] d, input logic z, input logic [15:0] s);
        sb.push_back({d, z, s});
    endtask

    task automatic drive(input logic [31:0] d, input logic z);
        alu_output = d;
        zero       = z;
        tick();
    endtask

    task automatic do_arm();
        arm        = 1'b1;
        alu_output = 32'h0;
        zero       = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (!(count == 5'd0 && sb.size() == 0) && k < 64) begin
            tick();
            k++;
        end
        chk({tag, "_drain_count"}, 64'(count), 64'd0);
        chk({tag, "_drain_sb"}, 64'(sb.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        alu_output   = 32'h0;
        zero         = 1'b0;
        arm          = 1'b0;
        trig_value   = 32'hDEAD_BEEF;
        trig_on_zero = 1'b0;
        cap_len      = 8'd0;
        out_ready    = 1'b0;
        tick();
        tick();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        // T2: value trigger, three samples
        trig_value = 32'h2A;
        cap_len    = 8'd3;
        do_arm();
        chk("t2_armed", 64'(state_o), 64'd1);
        drive(32'h28, 1'b0);
        drive(32'h29, 1'b0);
        expect_s(32'h2A, 1'b0, 16'd3);
        drive(32'h2A, 1'b0);
        chk("t2_capture", 64'(state_o), 64'd2);
        expect_s(32'h2B, 1'b0, 16'd4);
        drive(32'h2B, 1'b0);
        expect_s(32'h2C, 1'b0, 16'd5);
        drive(32'h2C, 1'b0);
        alu_output = 32'h0;
        chk("t2_done", 64'(state_o), 64'd3);
        chk("t2_count", 64'(count), 64'd3);
        chk("t2_head", 64'(out_data), 64'h2A);
        tick();
        chk("t2_hold_data", 64'(out_data), 64'h2A);
        chk("t2_hold_stamp", 64'(out_stamp), 64'd3);
        drain("t2");

        // T3: zero trigger with cap_len 0
        trig_value   = 32'hFFFF_FFFF;
        trig_on_zero = 1'b1;
        cap_len      = 8'd0;
        do_arm();
        drive(32'h11, 1'b0);
        expect_s(32'h12, 1'b1, 16'd2);
        drive(32'h12, 1'b1);
        drive(32'h13, 1'b0);
        chk("t3_done", 64'(state_o), 64'd3);
        chk("t3_count", 64'(count), 64'd1);
        chk("t3_zero", 64'(out_zero), 64'd1);
        trig_on_zero = 1'b0;
        drain("t3");

        // T4: overflow, 20 samples into 16 entries
        trig_value = 32'h100;
        cap_len    = 8'd20;
        do_arm();
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_s(32'h100 + 32'(i), 1'b0, 16'(i + 1));
            drive(32'h100 + 32'(i), 1'b0);
            if (i == 18) chk("t4_still_capture", 64'(state_o), 64'd2);
        end
        alu_output = 32'h0;
        chk("t4_done", 64'(state_o), 64'd3);
        chk("t4_count", 64'(count), 64'd16);
        chk("t4_ovf", 64'(overflow), 64'd1);
        drain("t4");
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);

        // T1: reset in the middle of a capture
        trig_value = 32'h600;
        cap_len    = 8'd10;
        do_arm();
        drive(32'h600, 1'b0);
        drive(32'h601, 1'b0);
        drive(32'h602, 1'b0);
        chk("t1_pre_state", 64'(state_o), 64'd2);
        chk("t1_pre_count", 64'(count), 64'd3);
        rst = 1'b1;
        tick();
        tick();
        chk("t1_state", 64'(state_o), 64'd0);
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_valid", 64'(out_valid), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;

        // T5: fill to full, then capture while draining
        trig_value = 32'h200;
        cap_len    = 8'd16;
        do_arm();
        for (int i = 0; i < 16; i++) begin
            expect_s(32'h200 + 32'(i), 1'b0, 16'(i + 1));
            drive(32'h200 + 32'(i), 1'b0);
        end
        chk("t5_full_count", 64'(count), 64'd16);
        chk("t5_full_ovf", 64'(overflow), 64'd0);
        trig_value = 32'h300;
        cap_len    = 8'd8;
        do_arm();
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            expect_s(32'h300 + 32'(i), 1'b0, 16'(i + 1));
            drive(32'h300 + 32'(i), 1'b0);
            chk("t5_count_steady", 64'(count), 64'd16);
        end
        alu_output = 32'h0;
        chk("t5_done", 64'(state_o), 64'd3);
        chk("t5_ovf", 64'(overflow), 64'd0);
        drain("t5");

        // T6: re-arm from DONE with two entries held
        trig_value = 32'h400;
        cap_len    = 8'd2;
        do_arm();
        drive(32'h3FF, 1'b0);
        expect_s(32'h400, 1'b0, 16'd2);
        drive(32'h400, 1'b0);
        expect_s(32'h401, 1'b0, 16'd3);
        drive(32'h401, 1'b0);
        chk("t6_first_done", 64'(state_o), 64'd3);
        chk("t6_first_count", 64'(count), 64'd2);
        trig_value = 32'h500;
        do_arm();
        chk("t6_rearmed", 64'(state_o), 64'd1);
        chk("t6_kept", 64'(count), 64'd2);
        expect_s(32'h500, 1'b0, 16'd1);
        drive(32'h500, 1'b0);
        expect_s(32'h501, 1'b0, 16'd2);
        drive(32'h501, 1'b0);
        alu_output = 32'h0;
        chk("t6_done", 64'(state_o), 64'd3);
        chk("t6_count", 64'(count), 64'd4);
        drain("t6");
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_empty_ready_count", 64'(count), 64'd0);
        chk("t6_empty_ready_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
